// File: rtl/cola_arbitro_wr.sv
// cola_arbitro_wr: round-robin burst arbiter sharing one cola_fifo write port among N producers
module cola_arbitro_wr #(
    parameter int W = 8,
    parameter int N = 4,
    parameter int S = 2,
    parameter int MAX_BURST = 8,
    parameter int C = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   last,
    input  logic [N*W-1:0] din,
    input  logic           fifo_full,
    output logic           fifo_wr,
    output logic [W-1:0]   fifo_din,
    output logic [N-1:0]   ack,
    output logic [N-1:0]   grant,
    output logic [S-1:0]   grant_id,
    output logic           busy
);
    typedef enum logic {IDLE, GNT} state_t;
    state_t state;
    logic [C-1:0] burst_cnt;
    logic [S-1:0] rr_ptr, sel;
    logic accept, done, drop;
    always_comb begin
        sel = '0;
        for (int k = N; k >= 1; k--)
            if (req[(int'(rr_ptr) + k) % N]) sel = S'((int'(rr_ptr) + k) % N);
    end
    assign busy     = state == GNT;
    assign accept   = busy & ~reset & req[grant_id] & ~fifo_full;
    assign done     = accept & (last[grant_id] | burst_cnt == C'(MAX_BURST - 1));
    assign drop     = busy & ~req[grant_id];
    assign fifo_wr  = accept;
    assign fifo_din = busy ? din[grant_id*W +: W] : '0;
    assign ack      = grant & {N{accept}};
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= '0;
            grant_id  <= '0;
            burst_cnt <= '0;
            rr_ptr    <= S'(N - 1);
        end else if (state == IDLE) begin
            if (|req) begin
                state     <= GNT;
                grant     <= N'(1) << sel;
                grant_id  <= sel;
                burst_cnt <= '0;
            end
        end else if (done | drop) begin
            state     <= IDLE;
            grant     <= '0;
            rr_ptr    <= grant_id;
            burst_cnt <= '0;
        end else if (accept) begin
            burst_cnt <= burst_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_cola_arbitro_wr.sv
// tb_cola_arbitro_wr: randomized scoreboard bench for the round-robin FIFO write arbiter
module tb_cola_arbitro_wr;
    localparam int W = 8, N = 4, S = 2, MB = 8, C = 4, D = 512;
    logic clk = 0, reset = 1, fifo_full = 0, fifo_wr, busy;
    logic [N-1:0] req = '0, last = '0, ack, grant;
    logic [N*W-1:0] din = '0;
    logic [W-1:0] fifo_din;
    logic [S-1:0] grant_id;
    int checks = 0, failures = 0;
    logic [W:0] pbuf [N][D];
    int head [N], tail [N];
    int owner = -1, cnt = 0, ptr = N - 1, last_id = 0;
    logic [N+W-1:0] exp_q [$];

    cola_arbitro_wr #(.W(W), .N(N), .S(S), .MAX_BURST(MB), .C(C)) dut (
        .clk(clk), .reset(reset), .req(req), .last(last), .din(din),
        .fifo_full(fifo_full), .fifo_wr(fifo_wr), .fifo_din(fifo_din),
        .ack(ack), .grant(grant), .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (fifo_wr === 1'b1) begin
            chk("wr_while_full", fifo_full, 0);
            if (exp_q.size() == 0) chk("unexpected_write", {ack, fifo_din}, 0);
            else chk("fifo_word", {ack, fifo_din}, exp_q.pop_front());
        end
    end

    task automatic add(input int i, input int n, input bit last_end, input int last_pct);
        for (int k = 0; k < n; k++) begin
            pbuf[i][tail[i] % D] = {(last_end && k == n - 1) || ($urandom_range(99) < last_pct), W'($urandom)};
            tail[i]++;
        end
    endtask

    task automatic cycle(input bit rst, input int full_pct, input int drop_pct, input logic [N-1:0] drop_mask);
        bit wr;
        logic [N-1:0] rv;
        @(posedge clk);
        #1;
        reset = rst;
        fifo_full = $urandom_range(99) < full_pct;
        for (int i = 0; i < N; i++) begin
            rv[i] = tail[i] > head[i] && !drop_mask[i] && $urandom_range(99) >= drop_pct;
            last[i] = pbuf[i][head[i] % D][W];
            din[i*W +: W] = tail[i] > head[i] ? pbuf[i][head[i] % D][W-1:0] : W'($urandom);
        end
        req = rv;
        wr = !rst && owner >= 0 && rv[owner] && !fifo_full;
        #1;
        chk("fifo_wr", fifo_wr, wr);
        chk("ack", ack, wr ? N'(1) << owner : 0);
        if (!rst) begin
            chk("grant", grant, owner >= 0 ? N'(1) << owner : 0);
            chk("busy", busy, owner >= 0);
            chk("grant_id", grant_id, last_id);
            chk("fifo_din", fifo_din, owner >= 0 ? din[owner*W +: W] : 0);
        end
        if (wr) exp_q.push_back({N'(1) << owner, din[owner*W +: W]});
        if (rst) begin
            owner = -1; cnt = 0; ptr = N - 1; last_id = 0;
            for (int i = 0; i < N; i++) head[i] = tail[i];
        end else if (owner < 0) begin
            for (int k = 1; k <= N && owner < 0; k++)
                if (rv[(ptr + k) % N]) begin owner = (ptr + k) % N; last_id = owner; cnt = 0; end
        end else if (wr) begin
            bit lw = pbuf[owner][head[owner] % D][W];
            head[owner]++;
            cnt++;
            if (lw || cnt == MB) begin ptr = owner; owner = -1; cnt = 0; end
        end else if (!rv[owner]) begin
            ptr = owner; owner = -1;
        end
    endtask

    task automatic drain(input string name, input int full_pct, input int drop_pct);
        int n = 0;
        bit busy_m = 1;
        while (busy_m && n < 2000) begin
            cycle(0, full_pct, drop_pct, '0);
            n++;
            busy_m = owner >= 0;
            for (int i = 0; i < N; i++) if (tail[i] > head[i]) busy_m = 1;
        end
        chk({"drain_timeout_", name}, busy_m, 0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; end
        cycle(1, 0, 0, '0);
        cycle(1, 0, 0, '0);
        cycle(0, 0, 0, '0);
        add(0, 3, 1, 0);
        drain("single", 0, 0);
        for (int i = 0; i < N; i++) add(i, 1, 1, 0);
        add(0, 1, 1, 0);
        drain("round_robin", 0, 0);
        add(2, 20, 1, 0);
        drain("max_burst", 0, 0);
        add(1, 6, 1, 0);
        cycle(0, 0, 0, '0);
        cycle(0, 0, 0, '0);
        repeat (3) cycle(0, 100, 0, '0);
        drain("full_stall", 0, 0);
        add(3, 5, 1, 0);
        add(0, 2, 1, 0);
        cycle(0, 0, 0, 4'b0001);
        cycle(0, 0, 0, 4'b0001);
        cycle(0, 0, 0, 4'b1000);
        cycle(0, 0, 0, '0);
        cycle(0, 0, 0, '0);
        drain("withdraw", 0, 0);
        add(0, 8, 0, 0);
        repeat (4) cycle(0, 0, 0, '0);
        cycle(1, 0, 0, '0);
        cycle(0, 0, 0, '0);
        add(1, 2, 1, 0);
        add(2, 2, 1, 0);
        drain("after_reset", 0, 0);
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < N; i++) add(i, $urandom_range(6), 0, 25);
            drain("random", 30, 10);
        end
        repeat (3) cycle(0, 0, 0, '0);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
